// File: rtl/rate_ctrl_pkg.sv
// Shared FSM state type and datapath widths for the rate_ctrl clock-path controller.
package rate_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int CNT_W      = 32;
    localparam int FREQ_W     = 16;
    localparam int DIV_CYCLES = 32;
endpackage

// File: rtl/rate_ctrl_seq_div32.sv
// Iterative restoring divider: one quotient bit per cycle, done asserted 32 cycles after start.
module seq_div32
    import rate_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [CNT_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [CNT_W-1:0] quotient
);
    logic             r_active;
    logic [5:0]       r_step;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_dvd;
    logic [CNT_W-1:0] r_dvs;
    logic [CNT_W-1:0] r_quo;
    logic [CNT_W-1:0] w_rem_in;
    logic [CNT_W-1:0] w_dvd_in;
    logic [CNT_W-1:0] w_dvs_in;
    logic [CNT_W-1:0] w_rem_nx;
    logic [CNT_W:0]   w_shift;
    logic [CNT_W:0]   w_trial;
    logic             w_fits;
    logic             w_adv;

    // The first quotient bit is produced on the start edge itself, from the raw operands.
    assign w_rem_in = start ? '0 : r_rem;
    assign w_dvd_in = start ? dividend : r_dvd;
    assign w_dvs_in = start ? divisor : r_dvs;
    assign w_shift  = {w_rem_in, w_dvd_in[CNT_W-1]};
    assign w_trial  = w_shift - {1'b0, w_dvs_in};
    assign w_fits   = ~w_trial[CNT_W];
    assign w_rem_nx = w_fits ? w_trial[CNT_W-1:0] : w_shift[CNT_W-1:0];

    assign done     = r_active && (r_step == 6'(DIV_CYCLES));
    assign w_adv    = start || (r_active && !done);
    assign quotient = r_quo;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_active <= 1'b0;
            r_step   <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_step   <= 6'd1;
        end else if (r_active) begin
            if (done) r_active <= 1'b0;
            else      r_step   <= r_step + 6'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_adv) begin
            r_rem <= w_rem_nx;
            r_dvd <= {w_dvd_in[CNT_W-2:0], 1'b0};
            r_dvs <= w_dvs_in;
            r_quo <= start ? {{(CNT_W-1){1'b0}}, w_fits} : {r_quo[CNT_W-2:0], w_fits};
        end
    end
endmodule

// File: rtl/rate_ctrl.sv
// Run-time clock divider controller: IDLE/RUN/PAUSE sequencing, clk_div/tick generation, live rate change.
// Optional feature macro RATE_CTRL_TICK_CNT_EN adds the tick_cnt[15:0] output.
module rate_ctrl
    import rate_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned DEF_FREQ = 1,
    parameter int unsigned MAX_FREQ = 1000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic              freq_load,
    output logic              freq_ack,
    output logic              freq_err,
    output logic              busy,
    output logic              running,
    output logic              clk_div,
`ifdef RATE_CTRL_TICK_CNT_EN
    output logic [15:0]       tick_cnt,
`endif
    output logic              tick
);
    localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(CLK_FREQ / (2 * DEF_FREQ));

    state_t           r_state;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_div;
    logic             r_tick;
    logic             r_running;
    logic             r_busy;
    logic             r_freq_ack;
    logic             r_freq_err;
    logic             w_load_ok;
    logic             w_freq_bad;
    logic             w_div_start;
    logic             w_div_done;
    logic [CNT_W-1:0] w_quotient;
    logic             w_wrap;
    logic             w_fall;

    assign w_load_ok   = freq_load && !r_busy;
    assign w_freq_bad  = (freq_in == '0) || (CNT_W'(freq_in) > MAX_FREQ);
    assign w_div_start = w_load_ok && !w_freq_bad;
    // A rate update owns the counter on its edge, so no wrap or toggle happens then.
    assign w_wrap      = (r_cnt == r_half - 32'd1) && !w_div_done;
    assign w_fall      = (r_state == RUN) && !stop && w_wrap && r_clk_div;

    seq_div32 u_div (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (w_div_start),
        .dividend (CNT_W'(CLK_FREQ)),
        .divisor  ({{(CNT_W-FREQ_W-1){1'b0}}, freq_in, 1'b0}),
        .done     (w_div_done),
        .quotient (w_quotient)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_half     <= DEF_HALF;
            r_cnt      <= '0;
            r_clk_div  <= 1'b0;
            r_tick     <= 1'b0;
            r_running  <= 1'b0;
            r_busy     <= 1'b0;
            r_freq_ack <= 1'b0;
            r_freq_err <= 1'b0;
        end else begin
            r_tick     <= w_fall;
            r_freq_ack <= 1'b0;
            r_freq_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt     <= '0;
                    r_clk_div <= 1'b0;
                    if (start && !stop && !pause) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                        r_cnt     <= '0;
                        r_clk_div <= 1'b0;
                    end else begin
                        if (w_wrap) begin
                            r_cnt     <= '0;
                            r_clk_div <= ~r_clk_div;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                        if (pause) begin
                            r_state   <= PAUSE;
                            r_running <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_clk_div <= 1'b0;
                    end else if (start && !pause) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
            endcase
            // Clearing cnt with the new half guarantees no overrun past a smaller period.
            if (w_div_done) begin
                r_half     <= w_quotient;
                r_cnt      <= '0;
                r_freq_ack <= 1'b1;
                r_busy     <= 1'b0;
            end else if (w_load_ok) begin
                if (w_freq_bad) r_freq_err <= 1'b1;
                else            r_busy     <= 1'b1;
            end
        end
    end

`ifdef RATE_CTRL_TICK_CNT_EN
    logic [15:0] r_tick_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)      r_tick_cnt <= '0;
        else if (stop)   r_tick_cnt <= '0;
        else if (w_fall) r_tick_cnt <= r_tick_cnt + 16'd1;
    end

    assign tick_cnt = r_tick_cnt;
`endif

    assign freq_ack = r_freq_ack;
    assign freq_err = r_freq_err;
    assign busy     = r_busy;
    assign running  = r_running;
    assign clk_div  = r_clk_div;
    assign tick     = r_tick;
endmodule

// File: tb/tb_rate_ctrl.sv
// Self-checking bench for rate_ctrl: scenario tasks plus randomized traffic against a behavioural model.
module tb_rate_ctrl;
    localparam int unsigned CLK_FREQ = 1000;
    localparam int unsigned DEF_FREQ = 100;
    localparam int unsigned MAX_FREQ = 500;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        stop = 1'b0;
    logic        freq_load = 1'b0;
    logic [15:0] freq_in = '0;
    logic        freq_ack, freq_err, busy, running, clk_div, tick;
`ifdef RATE_CTRL_TICK_CNT_EN
    logic [15:0] tick_cnt;
`endif

    int checks = 0;
    int errors = 0;

    rate_ctrl #(.CLK_FREQ(CLK_FREQ), .DEF_FREQ(DEF_FREQ), .MAX_FREQ(MAX_FREQ)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .pause(pause), .stop(stop),
        .freq_in(freq_in), .freq_load(freq_load), .freq_ack(freq_ack), .freq_err(freq_err),
        .busy(busy), .running(running), .clk_div(clk_div),
`ifdef RATE_CTRL_TICK_CNT_EN
        .tick_cnt(tick_cnt),
`endif
        .tick(tick)
    );

    always #5 CLK = ~CLK;

    // Behavioural reference: period bookkeeping in plain integers, division by '/',
    // and the rate change modelled as a 32-cycle countdown.
    int m_state = 0;  // 0 idle, 1 run, 2 pause
    int m_cnt = 0, m_half = 0, m_pend = 0, m_cd = 0;
    bit m_level = 0, m_tick = 0, m_run = 0, m_busy = 0, m_ack = 0, m_err = 0;

    task automatic model_step();
        bit upd;
        int nxt;
        if (!RST_N) begin
            m_state = 0; m_cnt = 0; m_half = CLK_FREQ / (2 * DEF_FREQ); m_pend = 0; m_cd = 0;
            m_level = 0; m_tick = 0; m_run = 0; m_busy = 0; m_ack = 0; m_err = 0;
            return;
        end
        upd = 0; nxt = m_state; m_tick = 0; m_ack = 0; m_err = 0;
        if (m_busy) begin
            m_cd--;
            upd = (m_cd == 0);
        end else if (freq_load) begin
            if (freq_in == 0 || freq_in > MAX_FREQ) m_err = 1;
            else begin m_busy = 1; m_cd = 32; m_pend = CLK_FREQ / (2 * freq_in); end
        end
        if (m_state != 0 && stop) begin
            nxt = 0; m_cnt = 0; m_level = 0;
        end else if (m_state == 0) begin
            if (start && !pause && !stop) nxt = 1;
        end else if (m_state == 1) begin
            if (!upd) begin
                m_cnt++;
                if (m_cnt >= m_half) begin
                    m_cnt = 0;
                    if (m_level) m_tick = 1;
                    m_level = !m_level;
                end
            end
            if (pause) nxt = 2;
        end else if (start && !pause) begin
            nxt = 1;
        end
        if (upd) begin m_half = m_pend; m_cnt = 0; m_busy = 0; m_ack = 1; end
        m_state = nxt;
        m_run = (nxt == 1);
    endtask

    always @(posedge CLK or negedge RST_N) model_step();

    wire [5:0] dut_vec = {clk_div, tick, running, busy, freq_ack, freq_err};

    function automatic logic [5:0] exp_vec();
        return {m_level, m_tick, m_run, m_busy, m_ack, m_err};
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            checks++;
            if (dut_vec !== 6'b0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %b expected %b", i, dut_vec, 6'b0);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reset_model cyc %0d: got %b expected %b", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_start();
        int rise_at;
        int ticks[$];
        rise_at = -1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int n = 0; n <= 25; n++) begin
            if (n > 0) @(negedge CLK);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL start_model n=%0d: got %b expected %b", n, dut_vec, exp_vec());
            end
            if (clk_div && rise_at < 0) rise_at = n;
            if (tick) ticks.push_back(n);
        end
        checks++;
        if (rise_at != 5) begin
            errors++;
            $display("FAIL start_first_rise: got %0d expected 5", rise_at);
        end
        checks++;
        if (ticks.size() != 2 || ticks[0] != 10 || ticks[1] != 20) begin
            errors++;
            $display("FAIL start_tick_period: got %0d ticks (first at %0d) expected ticks at 10,20",
                     ticks.size(), (ticks.size() > 0) ? ticks[0] : -1);
        end
    endtask

    task automatic test_pause();
        logic lvl;
        int tog_at;
        tog_at = -1;
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        pause = 1'b1;
        @(negedge CLK);
        lvl = clk_div;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge CLK);
            checks++;
            if (dut_vec !== exp_vec() || clk_div !== 1'b0 || running !== 1'b0) begin
                errors++;
                $display("FAIL pause_frozen i=%0d: got %b expected %b", i, dut_vec, exp_vec());
            end
        end
        pause = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (n > 0) @(negedge CLK);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL resume_model n=%0d: got %b expected %b", n, dut_vec, exp_vec());
            end
            if (clk_div !== lvl && tog_at < 0) tog_at = n;
        end
        checks++;
        if (tog_at != 3) begin
            errors++;
            $display("FAIL resume_toggle: got %0d cycles expected 3", tog_at);
        end
    endtask

    task automatic test_freq_change();
        int busy_cnt, ack_at;
        int ticks[$];
        busy_cnt = 0; ack_at = -1;
        freq_in = 16'd50;
        freq_load = 1'b1;
        for (int j = 1; j <= 80; j++) begin
            @(negedge CLK);
            freq_load = 1'b0;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL freq_model j=%0d: got %b expected %b", j, dut_vec, exp_vec());
            end
            if (busy) busy_cnt++;
            if (freq_ack && ack_at < 0) ack_at = j;
            if (tick) ticks.push_back(j);
        end
        checks++;
        if (busy_cnt != 32) begin
            errors++;
            $display("FAIL freq_busy_len: got %0d expected 32", busy_cnt);
        end
        checks++;
        if (ack_at != 33) begin
            errors++;
            $display("FAIL freq_ack_edge: got %0d expected 33", ack_at);
        end
        checks++;
        if (ticks.size() < 4 || ticks[1] - ticks[0] != 10 ||
            ticks[ticks.size()-1] - ticks[ticks.size()-2] != 20) begin
            errors++;
            $display("FAIL freq_periods: got %0d ticks expected old gap 10 and new gap 20", ticks.size());
        end
    endtask

    task automatic test_freq_err();
        int errs, acks;
        logic [15:0] bad [2];
        bad[0] = 16'd0;
        bad[1] = 16'd600;
        for (int b = 0; b < 2; b++) begin
            freq_in = bad[b];
            freq_load = 1'b1;
            @(negedge CLK);
            freq_load = 1'b0;
            checks++;
            if (freq_err !== 1'b1 || busy !== 1'b0 || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL freq_err_pulse in=%0d: got %b expected %b", bad[b], dut_vec, exp_vec());
            end
            @(negedge CLK);
            checks++;
            if (freq_err !== 1'b0) begin
                errors++;
                $display("FAIL freq_err_width in=%0d: got %b expected 0", bad[b], freq_err);
            end
        end
        errs = 0; acks = 0;
        freq_in = 16'd100;
        freq_load = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge CLK);
            freq_load = 1'b0;
            if (j == 5)  begin freq_in = 16'd0;   freq_load = 1'b1; end
            if (j == 10) begin freq_in = 16'd250; freq_load = 1'b1; end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL busy_load_model j=%0d: got %b expected %b", j, dut_vec, exp_vec());
            end
            if (freq_err) errs++;
            if (freq_ack) acks++;
        end
        freq_load = 1'b0;
        checks++;
        if (errs != 0 || acks != 1) begin
            errors++;
            $display("FAIL busy_load_ignored: got err=%0d ack=%0d expected err=0 ack=1", errs, acks);
        end
    endtask

    task automatic test_stop_reset();
        int rise_at, acks;
        for (int i = 0; i < 12 && m_cnt != 2; i++) @(negedge CLK);
        stop = 1'b1;
        pause = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        pause = 1'b0;
        checks++;
        if (clk_div !== 1'b0 || running !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL stop_pause_idle: got %b expected %b", dut_vec, exp_vec());
        end
        freq_in = 16'd25;
        freq_load = 1'b1;
        @(negedge CLK);
        freq_load = 1'b0;
        repeat (10) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        checks++;
        if (dut_vec !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_busy: got %b expected %b", dut_vec, 6'b0);
        end
        RST_N = 1'b1;
        acks = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge CLK);
            if (freq_ack) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL reset_discards_div: got %0d acks expected 0", acks);
        end
        rise_at = -1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (n > 0) @(negedge CLK);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset_model n=%0d: got %b expected %b", n, dut_vec, exp_vec());
            end
            if (clk_div && rise_at < 0) rise_at = n;
        end
        checks++;
        if (rise_at != 5) begin
            errors++;
            $display("FAIL post_reset_half: got first rise %0d expected 5", rise_at);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_model cyc %0d: got %b expected %b", c, dut_vec, exp_vec());
            end
            start     = ($urandom_range(0, 7) == 0);
            pause     = ($urandom_range(0, 23) == 0);
            stop      = ($urandom_range(0, 59) == 0);
            freq_load = ($urandom_range(0, 29) == 0);
            freq_in   = 16'($urandom_range(0, 650));
            RST_N     = ($urandom_range(0, 799) != 0);
        end
        start = 1'b0; pause = 1'b0; stop = 1'b0; freq_load = 1'b0; RST_N = 1'b1;
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause();
        test_freq_change();
        test_freq_err();
        test_stop_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
